// File: rtl/vga_data_bank_pkg.sv
// rtl/vga_data_bank_pkg.sv - shared constants, register map and state encoding for the VGA data bank
package vga_data_bank_pkg;

  localparam int NUM_REGS = 12;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;

  localparam logic [DATA_W-1:0] MAX_BCD    = 8'd99;
  localparam logic [DATA_W-1:0] CURSOR_MAX = 8'd9;

  localparam logic [ADDR_W-1:0] ADDR_SEG_RELOJ  = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_MIN_RELOJ  = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_HOR_RELOJ  = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_DAY_RELOJ  = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_MON_RELOJ  = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_YEAR_RELOJ = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_SEG_CRONO  = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_MIN_CRONO  = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_HOR_CRONO  = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_RING_CRONO = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_ACT_CRONO  = 4'd10;
  localparam logic [ADDR_W-1:0] ADDR_CURSOR     = 4'd11;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_e;

endpackage

// File: rtl/vga_data_bank_if.sv
// rtl/vga_data_bank_if.sv - write port, blanking strobe and display read port of the VGA data bank
interface vga_data_bank_if;
  import vga_data_bank_pkg::*;

  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WrValid;
  logic              WrReady;
  logic              WrError;
  logic              VBlankStart;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic              CopyBusy;

  modport master (
    output WrAddr, WrData, WrValid, VBlankStart, MemAddr,
    input  WrReady, WrError, MemData, CopyBusy
  );

  modport slave (
    input  WrAddr, WrData, WrValid, VBlankStart, MemAddr,
    output WrReady, WrError, MemData, CopyBusy
  );

endinterface

// File: rtl/vga_bank_write_check.sv
// rtl/vga_bank_write_check.sv - combinational legality check and masking of one control-side write
module vga_bank_write_check
  import vga_data_bank_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ok_o,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    ok_o   = 1'b0;
    data_o = data_i;
    if (addr_i <= ADDR_HOR_CRONO) begin
      ok_o = (data_i <= MAX_BCD);
    end else if (addr_i == ADDR_RING_CRONO || addr_i == ADDR_ACT_CRONO) begin
      // flags keep only their lsb, so any data byte is acceptable
      ok_o   = 1'b1;
      data_o = {{(DATA_W-1){1'b0}}, data_i[0]};
    end else if (addr_i == ADDR_CURSOR) begin
      ok_o = (data_i <= CURSOR_MAX);
    end
  end

endmodule

// File: rtl/vga_data_bank.sv
// rtl/vga_data_bank.sv - working/display register banks with a per-frame snapshot copy engine
module vga_data_bank
  import vga_data_bank_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  vga_data_bank_if.slave bus
);

  logic [DATA_W-1:0] work_q [NUM_REGS];
  logic [DATA_W-1:0] disp_q [NUM_REGS];
  state_e            state_q;
  logic              dirty_q;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_ready_q;
  logic              wr_error_q;
  logic              copy_busy_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] mem_data_d;

  logic              chk_ok;
  logic [DATA_W-1:0] chk_data;
  logic              accept;
  logic              wr_ok;

  vga_bank_write_check u_check (
    .addr_i (bus.WrAddr),
    .data_i (bus.WrData),
    .ok_o   (chk_ok),
    .data_o (chk_data)
  );

  assign accept = bus.WrValid && wr_ready_q;
  assign wr_ok  = accept && chk_ok;

  // addresses past the map fall through to zero
  always_comb begin
    mem_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.MemAddr == ADDR_W'(i)) mem_data_d = disp_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        work_q[i] <= '0;
        disp_q[i] <= '0;
      end
      state_q     <= IDLE;
      dirty_q     <= 1'b0;
      idx_q       <= '0;
      wr_ready_q  <= 1'b0;
      wr_error_q  <= 1'b0;
      copy_busy_q <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      mem_data_q <= mem_data_d;
      wr_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wr_ready_q <= 1'b1;
          if (accept) begin
            wr_error_q <= !chk_ok;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (chk_ok && bus.WrAddr == ADDR_W'(i)) work_q[i] <= chk_data;
            end
          end
          // a write landing on the blanking edge is already in work_q when the copy starts
          if (bus.VBlankStart && (dirty_q || wr_ok)) begin
            state_q     <= COPY;
            idx_q       <= '0;
            dirty_q     <= 1'b0;
            wr_ready_q  <= 1'b0;
            copy_busy_q <= 1'b1;
          end else begin
            dirty_q <= dirty_q || wr_ok;
          end
        end
        COPY: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == ADDR_W'(i)) disp_q[i] <= work_q[i];
          end
          if (idx_q == LAST_IDX) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wr_ready_q  <= 1'b1;
            copy_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.WrReady  = wr_ready_q;
  assign bus.WrError  = wr_error_q;
  assign bus.MemData  = mem_data_q;
  assign bus.CopyBusy = copy_busy_q;

endmodule

// File: tb/tb_vga_data_bank.sv
// tb/tb_vga_data_bank.sv - randomized and directed self-checking bench for vga_data_bank
module tb_vga_data_bank;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  vga_data_bank_if bus ();

  vga_data_bank dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // reference: what the display side must observe, from the register-map rules
  int m_work [12] = '{default: 0};
  int m_disp [12] = '{default: 0};
  bit m_dirty = 1'b0;
  int m_copy = -1;
  bit m_ready = 1'b0;
  bit m_err = 1'b0;
  int m_mem = 0;

  function automatic bit legal(int a, int d);
    if (a <= 8) return d <= 99;
    if (a == 9 || a == 10) return 1'b1;
    if (a == 11) return d <= 9;
    return 1'b0;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 12; i++) begin
        m_work[i] = 0;
        m_disp[i] = 0;
      end
      m_dirty = 0; m_copy = -1; m_ready = 0; m_err = 0; m_mem = 0;
    end else begin
      int a, d;
      bit wrote;
      a = int'(bus.WrAddr);
      d = int'(bus.WrData);
      m_mem = (int'(bus.MemAddr) < 12) ? m_disp[int'(bus.MemAddr)] : 0;
      m_err = 0;
      if (m_copy >= 0) begin
        m_disp[m_copy] = m_work[m_copy];
        m_copy = (m_copy == 11) ? -1 : m_copy + 1;
        m_ready = (m_copy < 0);
      end else begin
        wrote = 0;
        if (bus.WrValid && m_ready) begin
          if (legal(a, d)) begin
            m_work[a] = (a == 9 || a == 10) ? d % 2 : d;
            wrote = 1;
          end else begin
            m_err = 1;
          end
        end
        m_dirty = m_dirty | wrote;
        m_ready = 1;
        if (bus.VBlankStart && m_dirty) begin
          m_copy = 0;
          m_dirty = 0;
          m_ready = 0;
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    forever begin
      @(negedge CLK);
      check("model_WrReady", 32'(bus.WrReady), 32'(m_ready));
      check("model_WrError", 32'(bus.WrError), 32'(m_err));
      check("model_CopyBusy", 32'(bus.CopyBusy), 32'(m_copy >= 0));
      check("model_MemData", 32'(bus.MemData), 32'(m_mem));
    end
  end

  task automatic do_write(input int a, input int d, output int waited);
    waited = 0;
    bus.WrAddr = 4'(a); bus.WrData = 8'(d); bus.WrValid = 1'b1;
    while (!bus.WrReady && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 50) check("write_timeout", 32'(waited), 32'(0));
    @(negedge CLK);
    bus.WrValid = 1'b0;
  endtask

  task automatic pulse_vblank();
    bus.VBlankStart = 1'b1;
    @(negedge CLK);
    bus.VBlankStart = 1'b0;
  endtask

  task automatic wait_copy(output int n);
    n = 0;
    while (bus.CopyBusy && n < 50) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic read_check(string name, input int a, input int exp);
    bus.MemAddr = 4'(a);
    @(negedge CLK);
    check(name, 32'(bus.MemData), 32'(exp));
  endtask

  initial begin
    int w, n;
    bit rdy_prev;
    bus.WrAddr = '0; bus.WrData = '0; bus.WrValid = 1'b0;
    bus.VBlankStart = 1'b0; bus.MemAddr = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("post_reset_WrReady", 32'(bus.WrReady), 32'd1);
    for (int i = 0; i < 12; i++) read_check("reset_read", i, 0);

    do_write(2, 23, w);
    read_check("pre_copy_read2", 2, 0);
    pulse_vblank();
    wait_copy(n);
    check("copy_length", 32'(n), 32'd12);
    read_check("post_copy_read2", 2, 23);

    do_write(0, 100, w);
    check("err_bcd_pulse", 32'(bus.WrError), 32'd1);
    @(negedge CLK);
    check("err_bcd_clear", 32'(bus.WrError), 32'd0);
    do_write(11, 10, w);
    check("err_cursor_pulse", 32'(bus.WrError), 32'd1);
    do_write(13, 5, w);
    check("err_addr_pulse", 32'(bus.WrError), 32'd1);
    pulse_vblank();
    check("no_copy_when_clean", 32'(bus.CopyBusy), 32'd0);

    do_write(9, 8'hFF, w);
    pulse_vblank();
    wait_copy(n);
    read_check("flag_masked", 9, 1);
    do_write(11, 9, w);
    pulse_vblank();
    wait_copy(n);
    read_check("cursor_max", 11, 9);

    do_write(4, 44, w);
    pulse_vblank();
    do_write(5, 16, w);
    check("stall_cycles", 32'(w), 32'd12);
    read_check("stalled_not_yet", 5, 0);
    pulse_vblank();
    wait_copy(n);
    read_check("stalled_copied", 5, 16);

    rdy_prev = 1'b0;
    repeat (600) begin
      @(negedge CLK);
      if (!bus.WrValid || rdy_prev) begin
        bus.WrValid = ($urandom_range(0, 2) != 0);
        bus.WrAddr  = 4'($urandom_range(0, 15));
        bus.WrData  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 105));
      end
      rdy_prev = bus.WrReady;
      bus.VBlankStart = ($urandom_range(0, 9) == 0);
      bus.MemAddr = 4'($urandom_range(0, 15));
    end
    @(negedge CLK);
    bus.WrValid = 1'b0; bus.VBlankStart = 1'b0;
    wait_copy(n);

    do_write(3, 31, w);
    pulse_vblank();
    repeat (5) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("reset_busy_now", 32'(bus.CopyBusy), 32'd0);
    check("reset_ready_now", 32'(bus.WrReady), 32'd0);
    check("reset_mem_now", 32'(bus.MemData), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 12; i++) read_check("after_reset_read", i, 0);
    bus.WrAddr = 4'd7; bus.WrData = 8'd59; bus.WrValid = 1'b1; bus.VBlankStart = 1'b1;
    @(negedge CLK);
    bus.WrValid = 1'b0; bus.VBlankStart = 1'b0;
    wait_copy(n);
    check("same_cycle_copy_len", 32'(n), 32'd12);
    read_check("same_cycle_copied", 7, 59);
    read_check("out_of_map_read", 14, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_data_bank.md
Name: vga_data_bank

Overview:
- Register bank that serves the VGA pointer logic's per-frame register sweep, addresses 0..11, read-only from the display side.
- Written by the clock/chronometer control side through a valid/ready write port.
- Holds a working copy (written at any time) and a display copy (read by VGA). The display copy is refreshed by a 12-cycle copy engine at vertical-blank start, so the VGA side always sees one coherent snapshot per frame.

Parameters:
- NUM_REGS, 12, number of entries. Map: 0 segReloj, 1 minReloj, 2 horReloj, 3 dayReloj, 4 monReloj, 5 yearReloj, 6 segCrono, 7 minCrono, 8 horCrono, 9 ringCrono, 10 actCrono, 11 Cursor.
- DATA_W, 8, entry width.
- ADDR_W, 4, address width.
- MAX_BCD, 99, largest legal value for entries 0..8.
- CURSOR_MAX, 9, largest legal value for entry 11.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- WrAddr  in  4  write address.
- WrData  in  8  write data, binary.
- WrValid  in  1  write request.
- WrReady  out  1  bank can accept a write this cycle.
- WrError  out  1  one-cycle pulse when an accepted write is rejected.
- VBlankStart  in  1  one-cycle pulse at start of vertical blanking.
- MemAddr  in  4  display-side read address.
- MemData  out  8  display-side read data, registered.
- CopyBusy  out  1  high while the copy engine runs.

Behaviour:
- Reset (RESET=0, async): all working and display entries 0, MemData=0, WrError=0, CopyBusy=0, Dirty=0, state IDLE. WrReady=0 while RESET low, 1 in the first cycle after release.
- States: IDLE, COPY.
  - IDLE: WrReady=1.
  - COPY: WrReady=0, CopyBusy=1, copy index 0..11.
- Write handshake:
  - A write is accepted on a rising edge where WrValid && WrReady.
  - Master holds WrAddr/WrData/WrValid until accepted.
  - One write per cycle max.
- Write validation (at acceptance):
  - Addr 0..8: accepted if WrData <= 99, stored as is.
  - Addr 9, 10: stored as {7'b0, WrData[0]}, never an error.
  - Addr 11: accepted if WrData <= 9.
  - Addr 12..15, entry 0..8 data > 99, or Cursor > 9: working bank unchanged, WrError pulses high the next cycle for exactly 1 cycle.
  - A valid write sets Dirty. A rejected write does not.
- Copy trigger:
  - VBlankStart in IDLE with Dirty=1 (or Dirty being set by a write accepted in the same cycle): enter COPY next cycle, clear Dirty.
  - VBlankStart with Dirty=0: ignored.
  - VBlankStart during COPY: ignored; Dirty is preserved for the next blank.
- COPY:
  - One entry per cycle, display[i] <= working[i], i = 0..11.
  - On i = 11, return to IDLE. COPY lasts exactly 12 cycles; WrReady returns to 1 the cycle after the last copy.
  - Writes are stalled during COPY, so the snapshot is coherent.
- Read port:
  - MemData <= display[MemAddr] every cycle, 1-cycle latency, always enabled.
  - MemAddr 12..15 reads 0.
  - Reads during COPY return a mix of old and new entries. The display side is required to sample only outside blanking; that constraint belongs to the integration, not this block.
- Reset mid-COPY: async clear of all state. Both banks are 0 afterwards.
- Width rules: comparisons are unsigned 8-bit. The copy index is 4-bit and never exceeds 11.

Decomposition:
- Shared package: address constants for each entry (ADDR_SEG_RELOJ .. ADDR_CURSOR), NUM_REGS, MAX_BCD, CURSOR_MAX, and the state encoding (IDLE=1'b0, COPY=1'b1).
- One natural sub-module, vga_bank_write_check: combinational legality check (addr, data -> ok, masked data), reused by the control-side input path.

Test Plan:
1. Release reset, read addr 0..11 -> MemData=0 each, one cycle after addr. WrReady=1 from the first post-reset cycle.
2. Write addr 2 = 23, then VBlankStart -> CopyBusy high for 12 cycles, WrReady low for 12 cycles. Then read addr 2 -> 23. Before VBlankStart, read addr 2 -> 0.
3. Illegal writes -> WrError pulses 1 cycle each, Dirty stays 0, next VBlankStart starts no copy:
   - addr 0 = 100
   - addr 11 = 10
   - addr 13 = 5
4. Write addr 9 = 8'hFF -> after copy, read 9 = 8'h01. Write addr 11 = 9 -> read 9.
5. Hold WrValid with addr 5 = 16 asserted during COPY -> stalled until WrReady returns, accepted then. The next VBlankStart copies it; read 5 = 16.
6. Deassert RESET at copy cycle 6 -> all reads 0, CopyBusy=0 immediately. A write plus VBlankStart in the same cycle -> copy runs and includes the new value.
